// File: rtl/vector_add.sv
// Element-wise signed vector adder with per-element saturation.
// Operands are captured by independent handshakes; the sum is formed TILING elements per cycle.
module vector_add #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int TILING            = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
  input  logic                                    a_valid,
  output logic                                    a_ready,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
  input  logic                                    b_valid,
  output logic                                    b_ready,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic                                    error
);

  localparam int NUM_TILES = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int TILE_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int OP_W      = ((A_CELL_WIDTH > B_CELL_WIDTH) ? A_CELL_WIDTH : B_CELL_WIDTH) + 1;
  localparam int SUM_W     = (OP_W > RESULT_CELL_WIDTH) ? OP_W : RESULT_CELL_WIDTH;

  // Sums are kept at least as wide as the result so the clip bounds are always representable.
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - RESULT_CELL_WIDTH + 1){1'b0}}, {(RESULT_CELL_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                  state, state_n;
  logic                    a_held, b_held;
  logic [TILE_W-1:0]       tile_cnt;
  logic                    tile_last;
  logic                    a_fire, b_fire;
  logic                    sat_any;
  logic                    error_q;

  logic signed [A_CELL_WIDTH-1:0]      a_p0   [VECTOR_LEN];
  logic signed [B_CELL_WIDTH-1:0]      b_p0   [VECTOR_LEN];
  logic signed [SUM_W-1:0]             sum_p0 [VECTOR_LEN];
  logic signed [RESULT_CELL_WIDTH-1:0] res_p1 [VECTOR_LEN];

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] s);
    return (s > SAT_MAX) || (s < SAT_MIN);
  endfunction

  function automatic logic signed [RESULT_CELL_WIDTH-1:0] sat_clip(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[RESULT_CELL_WIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[RESULT_CELL_WIDTH-1:0];
    else                  return s[RESULT_CELL_WIDTH-1:0];
  endfunction

  assign a_ready      = (state == IDLE) && !a_held;
  assign b_ready      = (state == IDLE) && !b_held;
  assign a_fire       = a_valid && a_ready;
  assign b_fire       = b_valid && b_ready;
  assign tile_last    = (tile_cnt == TILE_W'(NUM_TILES - 1));
  assign result_valid = (state == DONE);
  assign error        = error_q;

  // Stage p0: operand capture
  always_ff @(posedge clk) begin
    if (a_fire) begin
      for (int i = 0; i < VECTOR_LEN; i++) a_p0[i] <= a[i*A_CELL_WIDTH +: A_CELL_WIDTH];
    end
    if (b_fire) begin
      for (int i = 0; i < VECTOR_LEN; i++) b_p0[i] <= b[i*B_CELL_WIDTH +: B_CELL_WIDTH];
    end
  end

  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < VECTOR_LEN; i++) begin
      sum_p0[i] = SUM_W'(a_p0[i]) + SUM_W'(b_p0[i]);
      if ((tile_cnt == TILE_W'(i / TILING)) && sat_hit(sum_p0[i])) sat_any = 1'b1;
    end
  end

  // Stage p1: saturated result tile and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VECTOR_LEN; i++) res_p1[i] <= '0;
      error_q <= 1'b0;
    end else if (state == COMPUTE) begin
      for (int i = 0; i < VECTOR_LEN; i++) begin
        if (tile_cnt == TILE_W'(i / TILING)) res_p1[i] <= sat_clip(sum_p0[i]);
      end
      if (sat_any) error_q <= 1'b1;
    end else if ((state == DONE) && result_ready) begin
      error_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < VECTOR_LEN; g++) begin : g_pack
    assign result[g*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = res_p1[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_held   <= 1'b0;
      b_held   <= 1'b0;
      tile_cnt <= '0;
    end else begin
      state <= state_n;
      if (a_fire) a_held <= 1'b1;
      if (b_fire) b_held <= 1'b1;
      // Held flags drop as the operation starts so the next IDLE visit re-opens both inputs.
      if ((state == IDLE) && a_held && b_held) begin
        a_held <= 1'b0;
        b_held <= 1'b0;
      end
      if (state == COMPUTE) tile_cnt <= tile_last ? '0 : tile_cnt + TILE_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (a_held && b_held) state_n = COMPUTE;
      COMPUTE: if (tile_last) state_n = DONE;
      DONE:    if (result_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_add.sv
// Bench for vector_add: three instances (TILING 2, 1, 5) share stimulus; a scoreboard
// queue holds expected results and a negedge monitor checks every result handshake.
module tb_vector_add;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] a, b;
  logic        a_valid, b_valid, result_ready;

  logic [39:0] res_w [3];
  logic        rv_w  [3];
  logic        er_w  [3];
  logic        ar_w  [3];
  logic        br_w  [3];

  typedef struct packed {
    logic [39:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q [$];
  int   rd_idx [3];
  int   checks = 0;
  int   errors = 0;
  int   exp_lat [3] = '{4, 6, 2};

  always #5 clk = ~clk;

  vector_add #(.TILING(2)) u_dut (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(ar_w[0]),
    .b(b), .b_valid(b_valid), .b_ready(br_w[0]), .result(res_w[0]),
    .result_valid(rv_w[0]), .result_ready(result_ready), .error(er_w[0]));

  vector_add #(.TILING(1)) u_t1 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(ar_w[1]),
    .b(b), .b_valid(b_valid), .b_ready(br_w[1]), .result(res_w[1]),
    .result_valid(rv_w[1]), .result_ready(result_ready), .error(er_w[1]));

  vector_add #(.TILING(5)) u_t5 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(ar_w[2]),
    .b(b), .b_valid(b_valid), .b_ready(br_w[2]), .result(res_w[2]),
    .result_valid(rv_w[2]), .result_ready(result_ready), .error(er_w[2]));

  function automatic logic [39:0] pack5(input int e0, input int e1, input int e2,
                                        input int e3, input int e4);
    return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every result handshake is compared against the next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (rv_w[d] && result_ready) begin
          if (rd_idx[d] >= exp_q.size()) begin
            chk($sformatf("unexpected_result_dut%0d", d), 64'(res_w[d]), 64'hDEAD);
          end else begin
            chk($sformatf("result_dut%0d_txn%0d", d, rd_idx[d]), 64'(res_w[d]), 64'(exp_q[rd_idx[d]].res));
            chk($sformatf("error_dut%0d_txn%0d", d, rd_idx[d]), 64'(er_w[d]), 64'(exp_q[rd_idx[d]].err));
          end
          rd_idx[d]++;
        end
      end
    end
  end

  task automatic wait_all_ready();
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = 1'b1;
      for (int d = 0; d < 3; d++) if (!(ar_w[d] && br_w[d])) ok = 1'b0;
      if (!ok) begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("wait_all_ready_timeout", 64'd0, 64'd1);
  endtask

  // Both operands offered on one cycle; checks capture-to-valid latency per instance.
  task automatic run_same(input logic [39:0] va, input logic [39:0] vb,
                          input logic [39:0] vr, input logic ve);
    int  lat [3];
    bit  seen [3];
    wait_all_ready();
    a = va; b = vb; a_valid = 1'b1; b_valid = 1'b1;
    exp_q.push_back('{res: vr, err: ve});
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin lat[d] = 0; seen[d] = 1'b0; end
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && rv_w[d]) begin lat[d] = n; seen[d] = 1'b1; end
      end
    end
    for (int d = 0; d < 3; d++) chk($sformatf("latency_dut%0d", d), 64'(lat[d]), 64'(exp_lat[d]));
  endtask

  logic [39:0] va1, vb1, vr1, va2, vb2, vr2, va3, vb3, vr3;
  logic [39:0] snap [3];
  bit          stable [3];

  initial begin
    va1 = pack5(-10, 20, 30, 40, -50);
    vb1 = pack5(5, 4, -3, 2, 1);
    vr1 = pack5(-5, 24, 27, 42, -49);
    va2 = pack5(-10, 20, 30, -128, 127);
    vb2 = pack5(5, 4, -3, -128, 127);
    vr2 = pack5(-5, 24, 27, -128, 127);
    va3 = pack5(100, -100, 127, -128, 1);
    vb3 = pack5(27, -28, 0, 0, -1);
    vr3 = pack5(127, -128, 127, -128, 0);
    for (int d = 0; d < 3; d++) rd_idx[d] = 0;

    rst = 1'b1; a = '0; b = '0; a_valid = 1'b0; b_valid = 1'b0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_a_ready_dut%0d", d), 64'(ar_w[d]), 64'd1);
      chk($sformatf("rst_b_ready_dut%0d", d), 64'(br_w[d]), 64'd1);
      chk($sformatf("rst_valid_dut%0d", d), 64'(rv_w[d]), 64'd0);
      chk($sformatf("rst_error_dut%0d", d), 64'(er_w[d]), 64'd0);
      chk($sformatf("rst_result_dut%0d", d), 64'(res_w[d]), 64'd0);
    end

    // a offered alone for 10 cycles, then b
    result_ready = 1'b1;
    a = va1; a_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("a_ready_after_capture", 64'(ar_w[0]), 64'd0);
    chk("b_ready_while_waiting", 64'(br_w[0]), 64'd1);
    repeat (9) @(posedge clk);
    #1;
    chk("a_ready_still_low", 64'(ar_w[0]), 64'd0);
    a = '1; a_valid = 1'b0;
    b = vb1; b_valid = 1'b1;
    exp_q.push_back('{res: vr1, err: 1'b0});
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    wait_all_ready();

    // Backpressure: result must hold while result_ready is low
    result_ready = 1'b0;
    begin
      bit all_v = 1'b0;
      wait_all_ready();
      a = va1; b = vb1; a_valid = 1'b1; b_valid = 1'b1;
      exp_q.push_back('{res: vr1, err: 1'b0});
      @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0;
      for (int n = 0; n < 20 && !all_v; n++) begin
        @(posedge clk);
        #1;
        all_v = rv_w[0] && rv_w[1] && rv_w[2];
      end
      chk("backpressure_all_valid", 64'(all_v), 64'd1);
    end
    for (int d = 0; d < 3; d++) begin snap[d] = res_w[d]; stable[d] = 1'b1; end
    repeat (12) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) if (!rv_w[d] || res_w[d] !== snap[d]) stable[d] = 1'b0;
    end
    for (int d = 0; d < 3; d++) chk($sformatf("hold_stable_dut%0d", d), 64'(stable[d]), 64'd1);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_hs_valid_dut%0d", d), 64'(rv_w[d]), 64'd0);
      chk($sformatf("post_hs_a_ready_dut%0d", d), 64'(ar_w[d]), 64'd1);
      chk($sformatf("post_hs_b_ready_dut%0d", d), 64'(br_w[d]), 64'd1);
    end

    // Saturation and exact-boundary vectors, operands on the same cycle
    result_ready = 1'b1;
    run_same(va2, vb2, vr2, 1'b1);
    run_same(va3, vb3, vr3, 1'b0);
    run_same(va1, vb1, vr1, 1'b0);

    // Reset in the middle of an operation: no result may appear
    result_ready = 1'b0;
    wait_all_ready();
    a = va2; b = vb2; a_valid = 1'b1; b_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_valid_dut%0d", d), 64'(rv_w[d]), 64'd0);
      chk($sformatf("abort_a_ready_dut%0d", d), 64'(ar_w[d]), 64'd1);
      chk($sformatf("abort_b_ready_dut%0d", d), 64'(br_w[d]), 64'd1);
      chk($sformatf("abort_error_dut%0d", d), 64'(er_w[d]), 64'd0);
    end
    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("abort_no_result_dut%0d", d), 64'(rv_w[d]), 64'd0);
    result_ready = 1'b1;
    run_same(va1, vb1, vr1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("results_consumed_dut%0d", d), 64'(rd_idx[d]), 64'(exp_q.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
